bitwise_and_checker: RTL

Self-checking response monitor for the 8-bit bitwise AND unit. It sits on the stimulus side of the unit under test and consumes each applied operand/result triple (A, B, C) through a valid/ready handshake. For every triple it recomputes A & B, compares the result against C, and keeps saturating pass/fail counts. It also captures the first mismatching triple. Benches and on-board self-test use it in place of manual waveform inspection.

---
 rtl/bitwise_and_pkg.sv | 17 +
 rtl/sat_counter.sv | 32 +++
 rtl/bitwise_and_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bitwise_and_pkg.sv
// Shared definitions for the bitwise AND response checker.
//   state_t      : checker run state (IDLE, RUN, DRAIN, DONE)
//   DEF_WIDTH    : default operand/result width
//   DEF_CNT_W    : default width of the pass/fail/accept counters
package bitwise_and_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one
//   cnt        : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/bitwise_and_checker.sv
// Response checker for an 8-bit bitwise AND unit. Accepts (A, B, C) triples
// over a valid/ready handshake, recomputes A & B, compares it with C and
// keeps saturating pass/fail counts plus the first failing triple.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start_i / stop_i     : begin a run (IDLE/DONE) / end it early (RUN)
//   n_vec_i              : triples to accept this run, sampled on start_i
//   vld_i, a_i, b_i, c_i : triple handshake and payload
//   rdy_o                : a triple is accepted this cycle if vld_i is high
//   pass_cnt_o/fail_cnt_o: saturating result counts
//   err_o                : sticky, at least one mismatch this run
//   ff_a_o/ff_b_o/ff_c_o : first failing triple
//   done_o, pass_o       : run complete / run complete and clean
module bitwise_and_checker
    import bitwise_and_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] n_vec_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic             rdy_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_o,
    output logic [WIDTH-1:0] ff_a_o,
    output logic [WIDTH-1:0] ff_b_o,
    output logic [WIDTH-1:0] ff_c_o,
    output logic             done_o,
    output logic             pass_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] n_vec;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept;
    logic             acc_last;
    logic             start_run;

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [WIDTH-1:0] c_p1;
    logic             match_p1;

    // Ready depends on registered state only, never on vld_i.
    assign rdy_o    = (state == ST_RUN) && (acc_cnt < n_vec);
    assign accept   = vld_i && rdy_o;
    assign acc_last = accept && ((acc_cnt + CNT_ONE) == n_vec);

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nxt = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                // The registered compare covers n_vec == 0; acc_last leaves
                // RUN in the same cycle as the final accept.
                if (stop_i || (acc_cnt == n_vec) || acc_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stage 2 is the counters themselves, so once stage 1 is
                // empty every accepted triple has been counted.
                if (!vld_p1) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            n_vec <= '0;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                n_vec <= n_vec_i;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_acc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .inc   (accept),
        .cnt   (acc_cnt)
    );

    // ---- stage 1: register accepted triple ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1 <= a_i;
            b_p1 <= b_i;
            c_p1 <= c_i;
        end
    end

    // ---- stage 2: compare and update counters / first-fail capture ----
    assign match_p1 = ((a_p1 & b_p1) == c_p1);

    sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .inc   (vld_p1 && match_p1),
        .cnt   (pass_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .inc   (vld_p1 && !match_p1),
        .cnt   (fail_cnt_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o  <= 1'b0;
            ff_a_o <= '0;
            ff_b_o <= '0;
            ff_c_o <= '0;
        end else if (start_run) begin
            err_o  <= 1'b0;
            ff_a_o <= '0;
            ff_b_o <= '0;
            ff_c_o <= '0;
        end else if (vld_p1 && !match_p1 && !err_o) begin
            // err_o doubles as the "already captured" flag.
            err_o  <= 1'b1;
            ff_a_o <= a_p1;
            ff_b_o <= b_p1;
            ff_c_o <= c_p1;
        end
    end

    assign done_o = (state == ST_DONE);
    assign pass_o = done_o && !err_o && (pass_cnt_o != '0);

endmodule
